// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite responder with a bank of byte-writable 32-bit registers
module axi_lite_slave_regs #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 32
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [31:0]       reg0_out
);

    localparam int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] RANGE_END = ADDR_W'(NUM_REGS * 4);
    localparam logic [1:0]        RESP_OKAY = 2'b00;
    localparam logic [1:0]        RESP_SLV  = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic [31:0]       regs [NUM_REGS];
    logic              ready_en;
    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [31:0]       rdata_q;

    logic              aw_take, w_take, ar_take, commit;
    logic [ADDR_W-1:0] cmt_addr;
    logic [31:0]       cmt_data;
    logic [3:0]        cmt_strb;
    logic              wr_in_range, rd_in_range;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    // Held address/data take precedence; otherwise the live bus is committed directly.
    assign cmt_addr    = aw_held ? aw_addr_q : AWADDR;
    assign cmt_data    = w_held ? w_data_q : WDATA;
    assign cmt_strb    = w_held ? w_strb_q : WSTRB;
    assign wr_in_range = cmt_addr < RANGE_END;
    assign wr_idx      = cmt_addr[2 +: IDX_W];
    assign rd_in_range = ARADDR < RANGE_END;
    assign rd_idx      = ARADDR[2 +: IDX_W];

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        aw_take   = 1'b0;
        w_take    = 1'b0;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                AWREADY = ready_en && !aw_held;
                WREADY  = ready_en && !w_held;
                aw_take = AWVALID && ready_en && !aw_held;
                w_take  = WVALID && ready_en && !w_held;
                if ((aw_held || aw_take) && (w_held || w_take)) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        ar_take   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ARREADY = ready_en;
                ar_take = ARVALID && ready_en;
                if (ar_take) r_state_d = R_RESP;
            end
            R_RESP: begin
                RVALID = 1'b1;
                if (RREADY) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            ready_en  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            ready_en <= 1'b1;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLV;
                if (wr_in_range) begin
                    for (int b = 0; b < 4; b++) begin
                        if (cmt_strb[b]) regs[wr_idx][8*b +: 8] <= cmt_data[8*b +: 8];
                    end
                end
            end else begin
                if (aw_take) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= AWADDR;
                end
                if (w_take) begin
                    w_held   <= 1'b1;
                    w_data_q <= WDATA;
                    w_strb_q <= WSTRB;
                end
            end
            // Register array is sampled before this edge's commit, so a racing read sees the old value.
            if (ar_take) begin
                rdata_q <= rd_in_range ? regs[rd_idx] : 32'h0;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLV;
            end
        end
    end

    assign BRESP    = bresp_q;
    assign RRESP    = rresp_q;
    assign RDATA    = rdata_q;
    assign reg0_out = regs[0];

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite responder (slave) holding a bank of NUM_REGS 32-bit read/write registers. It is the responder for axi_lite_master, and lets the master be verified end-to-end without the APB bridge. The write and read channels run independently. Byte strobes are honoured, and out-of-range accesses return SLVERR.

Parameters:
NUM_REGS, 8, number of 32-bit registers; power of two, 2..256
ADDR_W, 32, AXI address width

Ports:
aclk  in  1  clock
areset_n  in  1  synchronous active-low reset, sampled on rising aclk
AWADDR  in  ADDR_W  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WSTRB  in  4  byte strobes; bit i enables WDATA[8i+7:8i]
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response: 00 OKAY, 10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_W  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  read response: 00 OKAY, 10 SLVERR
RVALID  out  1  read data valid
RREADY  in  1  read data ready
reg0_out  out  32  live value of register 0, for control/debug

Behaviour:
- Reset (areset_n=0 at a rising edge):
  - All registers are cleared to 0.
  - BVALID, RVALID, AWREADY, WREADY and ARREADY go to 0.
  - BRESP, RRESP and RDATA go to 0.
  - Latched address/data flags are cleared.
  - Ready signals are high from the first cycle after reset release.
  - Reset mid-transaction aborts the transaction; no response is issued afterwards.
- Address decode:
  - Word index = addr[2 +: log2(NUM_REGS)].
  - addr[1:0] is ignored.
  - An address is in range iff addr < NUM_REGS*4.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: AWREADY = !aw_held and WREADY = !w_held.
    - An AW handshake latches the address and sets aw_held.
    - A W handshake latches data and strobe and sets w_held.
    - AW and W may arrive in either order or in the same cycle.
  - The commit occurs in the cycle in which both are held, or both are handshaking, or one is held and the other is handshaking.
    - The register is updated at the end of that cycle.
    - BVALID=1 in the next cycle.
    - The state moves to W_RESP and both held flags clear.
    - Fastest path: AW and W accepted in cycle N, register updated at the N/N+1 edge, BVALID in cycle N+1.
  - Commit when in range: per-byte update under WSTRB; BRESP=00. WSTRB=0000 leaves the register unchanged and still returns OKAY.
  - Commit when out of range: no register changes; BRESP=10.
  - W_RESP: AWREADY=WREADY=0. BVALID and BRESP are held stable until BREADY=1. The BVALID&BREADY cycle returns the FSM to W_IDLE; ready signals reassert the next cycle.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: ARREADY=1. An AR handshake in cycle N captures RDATA and RRESP at the edge, gives RVALID=1 in cycle N+1, and moves to R_RESP.
  - Out-of-range read: RDATA=0, RRESP=10.
  - R_RESP: ARREADY=0. RDATA, RRESP and RVALID are held stable until RREADY=1, then the FSM returns to R_IDLE.
- Simultaneous events:
  - A read captured in the same cycle as a write commit to the same register returns the pre-write value.
  - The read and write channels never stall each other.
- reg0_out reflects register 0 combinationally from the register (no extra delay after commit).
- Protection bits and AXI IDs are not supported; all accesses are single-beat.

Test Plan:
- Reset, then AW=0x04 and W=0xDEADBEEF with WSTRB=1111 in the same cycle, BREADY=1 -> BVALID in the next cycle with BRESP=00; a read of 0x04 returns 0xDEADBEEF with RRESP=00, RVALID one cycle after AR.
- W (0x11223344) presented 3 cycles before AW=0x08 -> WREADY drops after the W handshake; commit occurs on the AW cycle; reading 0x08 gives 0x11223344.
- Reg 0x0C=0xFFFFFFFF, then write 0x00000000 with WSTRB=0101 -> reading 0x0C returns 0xFF00FF00; reg0_out is unaffected.
- Write and read of address 0x20 with NUM_REGS=8 -> BRESP=10, RRESP=10, RDATA=0; all registers unchanged.
- BREADY and RREADY held low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stay stable; AWREADY/ARREADY stay 0 until the response handshake.
- areset_n=0 for 1 cycle while BVALID=1 and reg0=0x5 -> BVALID=0, reg0_out=0; the next write completes normally.
